rr_arb_mux: RTL

- Parametrised N-channel registered select stage for the CPU datapath; successor to the combinational 4:1 operand mux.
- Supports direct-select mode (fn_sel chooses the channel) and round-robin mode (fair arbitration among valid channels).
- Per-channel valid/ready handshake on inputs; one registered output slot with a valid/ready handshake.
- Sits between operand/request sources and the ALU or writeback consumer.

---
 rtl/cpu_sel_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/rr_arb_mux.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_sel_pkg.sv
// Shared definitions for the CPU datapath select stages.
//   sel_mode_e : how a select stage chooses its source channel
//   DEF_NUM_CH : default number of input channels
//   DEF_DATA_W : default per-channel data width
package cpu_sel_pkg;

  typedef enum logic {
    SEL_DIRECT = 1'b0,  // fn_sel names the channel
    SEL_RR     = 1'b1   // round-robin among valid channels
  } sel_mode_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     : per-channel request
//   ptr     : index of the last granted channel; the search begins at ptr+1
//   gnt     : one-hot grant, zero when nothing requests
//   gnt_idx : index of the granted channel (0 when no grant)
//   any_gnt : a grant was issued
module rr_arbiter import cpu_sel_pkg::*; #(
  parameter int  NUM_CH = DEF_NUM_CH,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  // Walk offsets 1..NUM_CH from ptr; offset NUM_CH revisits ptr itself, so the
  // last winner is considered only when nobody else requests. The inner loop
  // keeps every bit select constant, which also handles non power-of-2 counts.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!any_gnt && req[i] && (i == ((int'(ptr) + k) % NUM_CH))) begin
          gnt[i]  = 1'b1;
          gnt_idx = SEL_W'(i);
          any_gnt = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-channel select stage: direct select (mode 0) or round-robin
// arbitration (mode 1), feeding a single output slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 = direct select via fn_sel, 1 = round-robin
//   fn_sel     : channel index used in direct mode
//   in_data    : packed channel data, channel i at [i*DATA_W +: DATA_W]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, one-hot or zero
//   out_data   : registered data of the accepted beat
//   out_ch     : channel that produced out_data
//   out_valid  : output slot holds a beat
//   out_ready  : consumer takes the beat
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Sources keep data/valid stable until they see their ready; the
// output slot keeps out_data/out_ch/out_valid stable while out_ready is low.
module rr_arb_mux import cpu_sel_pkg::*; #(
  parameter int  NUM_CH = DEF_NUM_CH,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         fn_sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  logic              rr_mode;
  logic              load_en;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  assign rr_mode = (sel_mode_e'(mode) == SEL_RR);

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection. In direct mode an fn_sel beyond the last channel simply
  // matches no channel, so it yields no grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    if (rr_mode) begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
      any_gnt = rr_any;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((SEL_W'(i) == fn_sel) && in_valid[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = fn_sel;
          any_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Ready is held off while reset is asserted even though the empty slot
  // would otherwise advertise load_en.
  assign in_ready = (rst_n && load_en) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (load_en) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        // Direct-mode grants leave the pointer alone so round-robin fairness
        // picks up where it left off.
        if (rr_mode) rr_ptr <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
